// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO, multiply and multiply-accumulate in one cycle,
// and an iterative radix-2 restoring divider that stalls the pipeline via ready.
module hilo_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              ready,
    output logic              div_done,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        OP_MTHI  = 3'd0,
        OP_MTLO  = 3'd1,
        OP_MULT  = 3'd2,
        OP_MULTU = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_RUN,
        S_DIV_FIX
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  hi_q;
    logic [DATA_W-1:0]  lo_q;
    logic               div_done_q;

    // Divider working state
    logic [DATA_W-1:0]  rem_q;
    logic [DATA_W-1:0]  quo_q;
    logic [DATA_W-1:0]  dvs_q;
    logic [DATA_W-1:0]  dividend_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               div_zero_q;

    logic               accept;
    logic               is_div_op;
    logic               div_commit;
    op_e                op_dec;

    assign op_dec    = op_e'(op);
    assign ready     = (state_q == S_IDLE);
    assign accept    = op_valid && ready && !flush;
    assign is_div_op = (op_dec == OP_DIV) || (op_dec == OP_DIVU);

    // ------------------------------------------------------------------
    // Multiply / accumulate datapath (full 2*DATA_W, wraps modulo 2^PROD_W)
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] a_sext;
    logic [PROD_W-1:0] b_sext;
    logic [PROD_W-1:0] a_zext;
    logic [PROD_W-1:0] b_zext;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] prod_u;
    logic [PROD_W-1:0] hilo;
    logic [PROD_W-1:0] madd_res;
    logic [PROD_W-1:0] msub_res;

    assign a_sext   = {{DATA_W{src_a[DATA_W-1]}}, src_a};
    assign b_sext   = {{DATA_W{src_b[DATA_W-1]}}, src_b};
    assign a_zext   = {{DATA_W{1'b0}}, src_a};
    assign b_zext   = {{DATA_W{1'b0}}, src_b};
    // The low PROD_W bits of a sign-extended product are the exact signed product.
    assign prod_s   = a_sext * b_sext;
    assign prod_u   = a_zext * b_zext;
    assign hilo     = {hi_q, lo_q};
    assign madd_res = hilo + prod_s;
    assign msub_res = hilo - prod_s;

    // ------------------------------------------------------------------
    // Divider operand conditioning and one restoring step
    // ------------------------------------------------------------------
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   trial;
    logic              step_ok;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quo_step;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign a_neg = (op_dec == OP_DIV) && src_a[DATA_W-1];
    assign b_neg = (op_dec == OP_DIV) && src_b[DATA_W-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    assign trial    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
    assign step_ok  = !trial[DATA_W];
    assign rem_step = step_ok ? trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
    assign quo_step = {quo_q[DATA_W-2:0], step_ok};

    // Divide by zero bypasses sign fix-up so LO is all ones for DIV too.
    assign q_fix = div_zero_q ? {DATA_W{1'b1}} : (q_neg_q ? -quo_q : quo_q);
    assign r_fix = div_zero_q ? dividend_q     : (r_neg_q ? -rem_q : rem_q);

    assign div_commit = (state_q == S_DIV_FIX) && !flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_div_op) state_d = S_DIV_RUN;
            end
            S_DIV_RUN: begin
                if (flush)                             state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))           state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_done_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_done_q <= div_commit;

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        unique case (op_dec)
                            OP_MTHI:  hi_q <= src_a;
                            OP_MTLO:  lo_q <= src_a;
                            OP_MULT:  {hi_q, lo_q} <= prod_s;
                            OP_MULTU: {hi_q, lo_q} <= prod_u;
                            OP_MADD:  {hi_q, lo_q} <= madd_res;
                            OP_MSUB:  {hi_q, lo_q} <= msub_res;
                            OP_DIV, OP_DIVU: begin
                                rem_q      <= '0;
                                quo_q      <= a_mag;
                                dvs_q      <= b_mag;
                                dividend_q <= src_a;
                                q_neg_q    <= a_neg ^ b_neg;
                                r_neg_q    <= a_neg;
                                div_zero_q <= (src_b == '0);
                                cnt_q      <= CNT_W'(DATA_W);
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DIV_FIX: begin
                    if (!flush) begin
                        lo_q <= q_fix;
                        hi_q <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign div_done = div_done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: expected HI/LO pairs are queued when an op is
// driven and popped when the result becomes visible.
module tb_hilo_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         ready;
    logic         div_done;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [2*W-1:0] exp_q[$];
    string          tag_q[$];

    hilo_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .ready    (ready),
        .div_done (div_done),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required summary before timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic sb_push(input string tag, input logic [2*W-1:0] expv);
        exp_q.push_back(expv);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        logic [2*W-1:0] e;
        string          t;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL sb_underflow: observed empty queue, expected a pending result");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {hi_o, lo_o}, e);
        end
    endtask

    // Drive one request for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_div(output int stall, output int dones);
        stall = 0;
        dones = 0;
        while (ready !== 1'b1 && stall < 200) begin
            stall++;
            @(negedge clk);
            if (div_done === 1'b1) dones++;
        end
    endtask

    function automatic logic [2*W-1:0] div_model(input logic [2:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {a, {W{1'b1}}};
        if (o == 3'd4) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_div(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        int stall;
        int dones;
        sb_push(tag, div_model(o, a, b));
        issue(o, a, b);
        wait_div(stall, dones);
        check({tag, "_stall"}, 64'(stall), 64'(W + 1));
        check({tag, "_done_cnt"}, 64'(dones), 64'd1);
        check({tag, "_done_now"}, 64'(div_done), 64'd1);
        sb_check();
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(div_done), 64'd0);
    endtask

    initial begin
        int stall;
        int dones;
        int late_dones;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_div_done", 64'(div_done), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);

        // Moves to HI/LO
        sb_push("mthi", {32'h1234_5678, 32'h0});
        issue(3'd0, 32'h1234_5678, 32'h0);
        check("mthi_ready", 64'(ready), 64'd1);
        sb_check();
        sb_push("mtlo", {32'h1234_5678, 32'h9ABC_DEF0});
        issue(3'd1, 32'h9ABC_DEF0, 32'h0);
        check("mtlo_ready", 64'(ready), 64'd1);
        sb_check();

        // Signed vs unsigned multiply
        sb_push("mult", {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(3'd2, 32'hFFFF_FFFF, 32'h2);
        sb_check();
        sb_push("multu", {32'h0000_0001, 32'hFFFF_FFFE});
        issue(3'd3, 32'hFFFF_FFFF, 32'h2);
        sb_check();

        // A request coincident with flush in IDLE is dropped
        @(negedge clk);
        op_valid = 1'b1; op = 3'd0; src_a = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        check("flush_idle_drop", {hi_o, lo_o}, {32'h0000_0001, 32'hFFFF_FFFE});

        // Back-to-back MADD then MSUB
        sb_push("mthi_zero", {32'h0, 32'hFFFF_FFFE});
        issue(3'd0, 32'h0, 32'h0);
        sb_check();
        sb_push("mtlo_ten", {32'h0, 32'd10});
        issue(3'd1, 32'd10, 32'h0);
        sb_check();
        @(negedge clk);
        op_valid = 1'b1; op = 3'd6; src_a = 32'd3; src_b = 32'd4;
        sb_push("madd", {32'h0, 32'd22});
        @(negedge clk);
        op = 3'd7; src_a = 32'd5; src_b = 32'd5;
        sb_check();
        sb_push("msub", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(negedge clk);
        op_valid = 1'b0;
        sb_check();

        // Divides, including divide-by-zero and signed overflow
        run_div("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_7_0", 3'd5, 32'd7, 32'd0);
        run_div("div_m7_0", 3'd4, 32'hFFFF_FFF9, 32'd0);
        run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("div_100_7", 3'd4, 32'd100, 32'd7);
        run_div("div_m100_7", 3'd4, -32'sd100, 32'd7);
        run_div("div_100_m7", 3'd4, 32'd100, -32'sd7);
        run_div("div_m100_m7", 3'd4, -32'sd100, -32'sd7);
        run_div("divu_big_3", 3'd5, 32'hFFFF_FFFF, 32'd3);

        // op_valid held through the stall: second accept only in the div_done cycle
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; src_a = 32'h8000_0000; src_b = 32'hFFFF_FFFF;
        sb_push("held_first", {32'h0, 32'h8000_0000});
        sb_push("held_second", {32'h0, 32'h8000_0000});
        @(negedge clk);
        wait_div(stall, dones);
        check("held_first_stall", 64'(stall), 64'(W + 1));
        check("held_first_done", 64'(dones), 64'd1);
        sb_check();
        @(negedge clk);
        op_valid = 1'b0;
        check("held_second_accept", 64'(ready), 64'd0);
        check("held_done_not_twice", 64'(div_done), 64'd0);
        wait_div(stall, dones);
        check("held_second_stall", 64'(stall), 64'(W + 1));
        sb_check();
        @(negedge clk);

        // Flush mid-divide leaves HI/LO untouched
        sb_push("set_hi55", {32'h55, 32'h8000_0000});
        issue(3'd0, 32'h55, 32'h0);
        sb_check();
        sb_push("set_lo55", {32'h55, 32'h55});
        issue(3'd1, 32'h55, 32'h0);
        sb_check();
        issue(3'd4, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_hilo", {hi_o, lo_o}, {32'h55, 32'h55});
        late_dones = 0;
        for (int i = 0; i < W + 8; i++) begin
            if (div_done === 1'b1) late_dones++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(late_dones), 64'd0);
        check("flush_hilo_later", {hi_o, lo_o}, {32'h55, 32'h55});

        // Reset mid-divide discards it and clears HI/LO
        issue(3'd4, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 64'(ready), 64'd1);
        check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_mid_done", 64'(div_done), 64'd0);
        sb_push("post_rst_mtlo", {32'h0, 32'hA5A5_0001});
        issue(3'd1, 32'hA5A5_0001, 32'h0);
        sb_check();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
